// File: rtl/qos_pkg.sv
// Shared QoS constants, occupancy state encoding and channel decode helper
// for the egress demultiplexer.
package qos_pkg;

  localparam int WORD_W = 12;  // datapath word width
  localparam int CH_LSB = 8;   // channel field low bit
  localparam int CH_MSB = 9;   // channel field high bit
  localparam int N_CH   = 4;   // number of egress channels
  localparam int DEPTH  = 2;   // in-order buffer depth
  localparam int CNT_W  = 8;   // per-channel push counter width

  // Buffer occupancy state; the encoding equals the occupancy value.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // One-hot select for a 2-bit channel number.
  function automatic logic [N_CH-1:0] ch_onehot(input logic [1:0] ch);
    logic [N_CH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order word buffer with head/tail pointers and an occupancy
// count. A push into a full buffer or a pop from an empty one is ignored.
module skid_buf2
  import qos_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              do_push;
  logic              do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_push = push && (count_q != 2'(DEPTH));
    do_pop  = pop && (count_q != 2'd0);
    if (do_push) begin
      mem_d[tail_q] = din;
      tail_d        = ~tail_q;
    end
    if (do_pop) begin
      head_d = ~head_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // Buffer state registers; reset discards any stored words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/demux_egress.sv
// Egress demultiplexer: buffers words from the upstream arbiter and pushes
// each one to the egress FIFO selected by data_in[9:8], head-of-line order.
// Optional per-channel push counters: define DEMUX_EGRESS_COUNTERS_EN.
//
// Handshake: a word is accepted on an edge where valid_in=1, stall_out=0 and
// the buffer holds fewer than 2 words. stall_out is registered, so upstream
// sees it one cycle late; valid_in while the buffer is full loses the word
// and sets the sticky overflow_out. Downstream has no ready: almost_full_in[n]
// high simply withholds push_out[n], and push_out is a one-cycle strobe.
module demux_egress
  import qos_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    data_in,
  input  logic                 valid_in,
  input  logic [N_CH-1:0]      almost_full_in,
  output logic                 stall_out,
  output logic [N_CH-1:0]      push_out,
  output logic [WORD_W-1:0]    data_out,
  output logic                 overflow_out,
  output logic [N_CH*CNT_W-1:0] cnt_out,
  output logic [1:0]           state_out
);

  occ_state_e        state_q, state_d;
  logic [N_CH-1:0]   push_q, push_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              stall_q, stall_d;
  logic              overflow_q, overflow_d;

  logic [WORD_W-1:0] head_word;
  logic [1:0]        buf_count;
  logic [1:0]        head_ch;
  logic              eligible;
  logic              accept;
  logic [1:0]        occ_next;

  skid_buf2 u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (eligible),
    .din   (data_in),
    .dout  (head_word),
    .count (buf_count)
  );

  // Accept/pop decisions and registered output next-values.
  always_comb begin
    head_ch    = head_word[CH_MSB:CH_LSB];
    eligible   = (buf_count != 2'd0) && !almost_full_in[head_ch];
    accept     = valid_in && !stall_q && (buf_count < 2'(DEPTH));
    occ_next   = buf_count + 2'(accept) - 2'(eligible);
    push_d     = '0;
    data_d     = data_q;
    if (eligible) begin
      push_d = ch_onehot(head_ch);
      data_d = head_word;
    end
    stall_d    = (occ_next == 2'(DEPTH)) || (almost_full_in != '0);
    overflow_d = overflow_q || (valid_in && (buf_count == 2'(DEPTH)));
  end

  // Occupancy state machine, tracking the buffer count transition by transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !eligible)      state_d = FULL;
        else if (eligible && !accept) state_d = EMPTY;
      end
      FULL:    if (eligible) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // State and registered outputs; reset wins over any accept or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      push_q     <= '0;
      data_q     <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign stall_out    = stall_q;
  assign push_out     = push_q;
  assign data_out     = data_q;
  assign overflow_out = overflow_q;
  assign state_out    = state_q;

`ifdef DEMUX_EGRESS_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Count every push strobe per channel, wrapping naturally.
  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < N_CH; n++) begin
      if (push_d[n]) cnt_d[n] = cnt_q[n] + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < N_CH; n++) cnt_q[n] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pack counters, channel n at [8n+7:8n].
  always_comb begin
    cnt_out = '0;
    for (int n = 0; n < N_CH; n++) cnt_out[n*CNT_W +: CNT_W] = cnt_q[n];
  end
`else
  assign cnt_out = '0;
`endif

endmodule
